led_pattern_gen: RTL and testbench

Multi-channel, run-time programmable LED pattern generator. Each channel runs an independent Moore FSM driving one LED as off, solid on, continuous blink with programmable on/off durations, or a single timed pulse. All channels share one prescaler that turns `clk` into a slow time base. The block sits between the board's LED pins and any control logic or register bank that writes channel configurations.

---
 rtl/led_pattern_pkg.sv | 34 +++
 rtl/led_pattern_chan.sv | 139 +++++++++++++
 rtl/led_pattern_gen.sv | 90 +++++++++
 tb/tb_led_pattern_gen.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pattern_pkg.sv
// ---------------------------------------------------------------------------
// led_pattern_pkg
// Shared types and helpers for the LED pattern generator.
//   mode_t        : channel mode as written over the configuration port
//   chan_state_t  : per-channel Moore FSM states
//   state_is_lit  : LED drive level for a given channel state
//   ch_idx_width  : width of a channel index for a given channel count (min 1)
// ---------------------------------------------------------------------------
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_SOLID = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PULSE = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOLID,
    ST_BLINK_ON,
    ST_BLINK_OFF,
    ST_PULSE_ON
  } chan_state_t;

  function automatic logic state_is_lit(input chan_state_t s);
    return (s == ST_SOLID) || (s == ST_BLINK_ON) || (s == ST_PULSE_ON);
  endfunction

  function automatic int ch_idx_width(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/led_pattern_chan.sv
// ---------------------------------------------------------------------------
// led_pattern_chan
// One LED channel: Moore FSM, latched on/off durations and the tick-based
// duration counter. The written mode is carried by the FSM state itself.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   i_tick          : one-cycle time-base strobe from the shared prescaler
//   i_load          : accepted configuration write aimed at this channel
//   i_mode          : mode of the write (mode_t encoding)
//   i_on, i_off     : on/off durations in ticks
//   o_led           : registered LED drive, 1 = lit
//   o_active        : registered, channel is not IDLE
//   o_pulse_done    : one-cycle strobe in the cycle the PULSE LED falls
// ---------------------------------------------------------------------------
module led_pattern_chan
  import led_pattern_pkg::*;
#(
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_tick,
  input  logic          i_load,
  input  logic [1:0]    i_mode,
  input  logic [TW-1:0] i_on,
  input  logic [TW-1:0] i_off,
  output logic          o_led,
  output logic          o_active,
  output logic          o_pulse_done
);

  chan_state_t   r_state;
  chan_state_t   w_state_nxt;
  logic [TW-1:0] r_cnt;
  logic [TW-1:0] w_cnt_nxt;
  logic [TW-1:0] r_on;
  logic [TW-1:0] r_off;
  logic          w_done;
  logic          r_done_pend;
  logic          r_led;
  logic          r_active;
  logic          r_pulse_done;

  // The phase-end compare never sees r_on/r_off == 0 in a phase that uses
  // it: such phases are either never entered or held statically below.
  logic w_on_last;
  logic w_off_last;
  assign w_on_last  = (r_cnt == r_on  - TW'(1));
  assign w_off_last = (r_cnt == r_off - TW'(1));

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done      = 1'b0;
    if (i_load) begin
      // A write always wins over a coincident tick and restarts the pattern.
      w_cnt_nxt = '0;
      case (i_mode)
        MODE_OFF:   w_state_nxt = ST_IDLE;
        MODE_SOLID: w_state_nxt = ST_SOLID;
        MODE_BLINK: w_state_nxt = (i_on == '0) ? ST_BLINK_OFF : ST_BLINK_ON;
        MODE_PULSE: w_state_nxt = (i_on == '0) ? ST_IDLE : ST_PULSE_ON;
        default:    w_state_nxt = ST_IDLE;
      endcase
    end else if (i_tick) begin
      case (r_state)
        ST_BLINK_ON: begin
          // off == 0 means "constant lit": never leave the on phase.
          if (r_off != '0) begin
            if (w_on_last) begin
              w_state_nxt = ST_BLINK_OFF;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + TW'(1);
            end
          end
        end
        ST_BLINK_OFF: begin
          // on == 0 means "constant dark": never leave the off phase.
          if (r_on != '0) begin
            if (w_off_last) begin
              w_state_nxt = ST_BLINK_ON;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + TW'(1);
            end
          end
        end
        ST_PULSE_ON: begin
          if (w_on_last) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_done      = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the asynchronous reset clears every register here, including the
  // stored durations, so a reset leaves no trace of the previous pattern.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_on         <= '0;
      r_off        <= '0;
      r_done_pend  <= 1'b0;
      r_led        <= 1'b0;
      r_active     <= 1'b0;
      r_pulse_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (i_load) begin
        r_on  <= i_on;
        r_off <= i_off;
      end
      // Outputs follow the state one edge later; the done strobe is delayed
      // by the same amount so it lines up with the LED falling edge.
      r_led        <= state_is_lit(r_state);
      r_active     <= (r_state != ST_IDLE);
      r_done_pend  <= w_done;
      r_pulse_done <= r_done_pend;
    end
  end

  assign o_led        = r_led;
  assign o_active     = r_active;
  assign o_pulse_done = r_pulse_done;

endmodule

// File: rtl/led_pattern_gen.sv
// ---------------------------------------------------------------------------
// led_pattern_gen
// Multi-channel programmable LED pattern generator. A shared prescaler turns
// clk into a TICK_HZ time base; each channel runs its own pattern FSM.
// Ports:
//   clk, rst    : clock, asynchronous active-low reset
//   cfg_valid   : configuration write strobe
//   cfg_ready   : configuration accept, high whenever reset is released
//   cfg_ch      : target channel (writes to cfg_ch >= CH are dropped)
//   cfg_mode    : 0=OFF 1=SOLID 2=BLINK 3=PULSE
//   cfg_on/off  : on/off durations in ticks
//   led         : registered LED drive per channel, 1 = lit
//   active      : channel not IDLE
//   pulse_done  : one-cycle strobe as a PULSE completes
// DIV = CLK_HZ/TICK_HZ must be an integer >= 2.
// ---------------------------------------------------------------------------
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int CLK_HZ  = 27_000_000,
  parameter int TICK_HZ = 1000,
  parameter int CH      = 4,
  parameter int TW      = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 cfg_valid,
  output logic                                 cfg_ready,
  input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] cfg_ch,
  input  logic [1:0]                           cfg_mode,
  input  logic [TW-1:0]                        cfg_on,
  input  logic [TW-1:0]                        cfg_off,
  output logic [CH-1:0]                        led,
  output logic [CH-1:0]                        active,
  output logic [CH-1:0]                        pulse_done
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int DW  = $clog2(DIV);
  localparam int CHW = ch_idx_width(CH);
  // One bit wider than cfg_ch so CH itself is representable for the range check.
  localparam logic [CHW:0] CH_LIM = (CHW + 1)'(CH);

  // Free-running prescaler; configuration writes never restart it, so all
  // channels share one phase-aligned time base.
  logic [DW-1:0] r_div_cnt;
  logic          w_tick;

  assign w_tick = (r_div_cnt == DW'(DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_cnt <= '0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DW'(1);
    end
  end

  // The block can always take a write once out of reset.
  assign cfg_ready = rst;

  logic          w_accept;
  logic          w_ch_ok;
  logic [CH-1:0] w_load;

  assign w_accept = cfg_valid && cfg_ready;
  assign w_ch_ok  = ({1'b0, cfg_ch} < CH_LIM);

  for (genvar g = 0; g < CH; g++) begin : g_chan
    assign w_load[g] = w_accept && w_ch_ok && (cfg_ch == CHW'(g));

    led_pattern_chan #(
      .TW (TW)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .i_tick       (w_tick),
      .i_load       (w_load[g]),
      .i_mode       (cfg_mode),
      .i_on         (cfg_on),
      .i_off        (cfg_off),
      .o_led        (led[g]),
      .o_active     (active[g]),
      .o_pulse_done (pulse_done[g])
    );
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_led_pattern_gen
// Drives a CH=4 instance and a CH=3 instance with the same configuration
// stream (DIV = 10, TW = 8). Expected outputs come from an arithmetic model:
// per channel it remembers the last write and the number of ticks seen since,
// and derives the LED level from the blink period / pulse length.
// ---------------------------------------------------------------------------
module tb_led_pattern_gen;

  localparam int CLK_HZ  = 100;
  localparam int TICK_HZ = 10;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int TW      = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic [1:0]    cfg_ch;
  logic [1:0]    cfg_mode;
  logic [TW-1:0] cfg_on;
  logic [TW-1:0] cfg_off;

  logic       rdy4, rdy3;
  logic [3:0] led4, act4, pd4;
  logic [2:0] led3, act3, pd3;

  always #5 clk = ~clk;

  led_pattern_gen #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .CH(4), .TW(TW)) u_dut4 (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(rdy4), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_on(cfg_on), .cfg_off(cfg_off),
    .led(led4), .active(act4), .pulse_done(pd4)
  );

  led_pattern_gen #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .CH(3), .TW(TW)) u_dut3 (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(rdy3), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_on(cfg_on), .cfg_off(cfg_off),
    .led(led3), .active(act3), .pulse_done(pd3)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int   m_k;           // edges since reset release
  int   m_mode [4];
  int   m_on   [4];
  int   m_off  [4];
  int   m_n    [4];    // ticks counted since the last write
  bit   m_done_prev [4];
  logic [3:0] exp_led, exp_act, exp_pd;

  function automatic bit model_lit(int mode, int on, int off, int n);
    case (mode)
      1:       return 1'b1;
      2:       return (on == 0) ? 1'b0 : (off == 0) ? 1'b1 : ((n % (on + off)) < on);
      3:       return (on != 0) && (n < on);
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit model_act(int mode, int on, int n);
    case (mode)
      1, 2:    return 1'b1;
      3:       return (on != 0) && (n < on);
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_k = 0;
    for (int c = 0; c < 4; c++) begin
      m_mode[c] = 0; m_on[c] = 0; m_off[c] = 0; m_n[c] = 0; m_done_prev[c] = 1'b0;
    end
    exp_led = '0; exp_act = '0; exp_pd = '0;
  endtask

  task automatic model_edge(input bit v, input int ch, input int mode, input int on, input int off);
    bit tick;
    bit done;
    m_k++;
    tick = (m_k % DIV == 0);
    for (int c = 0; c < 4; c++) begin
      exp_led[c] = model_lit(m_mode[c], m_on[c], m_off[c], m_n[c]);
      exp_act[c] = model_act(m_mode[c], m_on[c], m_n[c]);
      exp_pd[c]  = m_done_prev[c];
      done = 1'b0;
      if (v && ch == c) begin
        m_mode[c] = mode; m_on[c] = on; m_off[c] = off; m_n[c] = 0;
      end else if (tick) begin
        m_n[c]++;
        done = (m_mode[c] == 3) && (m_on[c] != 0) && (m_n[c] == m_on[c]);
      end
      m_done_prev[c] = done;
    end
  endtask

  task automatic compare_all();
    check("led",        {4'b0, led4}, {4'b0, exp_led});
    check("active",     {4'b0, act4}, {4'b0, exp_act});
    check("pulse_done", {4'b0, pd4},  {4'b0, exp_pd});
    check("ch3_build",  {led3, act3, pd3}, {exp_led[2:0], exp_act[2:0], exp_pd[2:0]});
    check("cfg_ready",  {6'b0, rdy4, rdy3}, {6'b0, rst, rst});
  endtask

  // One clock: present inputs, take the edge, update the model, sample at +1.
  task automatic cycle(input bit v, input int ch, input int mode, input int on, input int off);
    cfg_valid = v;
    cfg_ch    = ch[1:0];
    cfg_mode  = mode[1:0];
    cfg_on    = on[TW-1:0];
    cfg_off   = off[TW-1:0];
    @(posedge clk);
    if (rst) model_edge(v, ch, mode, on, off);
    #1;
    cfg_valid = 1'b0;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  // Reset asserted between edges must clear outputs without waiting for clk.
  task automatic async_reset();
    #2 rst = 1'b0;
    #1;
    check("async_rst_led", {4'b0, led4}, 8'h00);
    check("async_rst_out", {act4, pd4}, 8'h00);
    check("async_rst_rdy", {6'b0, rdy4, rdy3}, 8'h00);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst = 1'b1;
  endtask

  initial begin
    int runs[$];
    int run;
    bit prev;
    int hi_len, pd_cnt;
    bit found;
    logic [8:0] snap;

    rst = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_on = '0; cfg_off = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    rst = 1'b1;

    // 1. Quiet after reset.
    idle(15);
    check("idle_led", {4'b0, led4}, 8'h00);

    // 2. ch0 BLINK on=2 off=1: measure consecutive run lengths of led[0].
    cycle(1, 0, 2, 2, 1);
    runs.delete();
    run = 0; prev = 1'b0;
    for (int i = 0; i < 80; i++) begin
      cycle(0, 0, 0, 0, 0);
      if (led4[0] == prev) run++;
      else begin runs.push_back(run); run = 1; prev = led4[0]; end
    end
    check("blink_runs", 8'(runs.size() >= 5), 8'd1);
    if (runs.size() >= 5) begin
      check("blink_off1", 8'(runs[2]), 8'd10);
      check("blink_on2",  8'(runs[3]), 8'd20);
      check("blink_off2", 8'(runs[4]), 8'd10);
    end

    // Reset while ch0 is lit.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (exp_led[0]) found = 1'b1;
      else cycle(0, 0, 0, 0, 0);
    end
    check("wait_lit", 8'(found), 8'd1);
    async_reset();
    idle(3);

    // 3. ch1 PULSE on=3.
    cycle(1, 1, 3, 3, 0);
    hi_len = 0; pd_cnt = 0; prev = 1'b0;
    for (int i = 0; i < 45; i++) begin
      cycle(0, 0, 0, 0, 0);
      if (led4[1]) hi_len++;
      if (pd4[1]) begin
        pd_cnt++;
        check("pd_align", {6'b0, prev, led4[1]}, 8'b10);
      end
      prev = led4[1];
    end
    check("pulse_len_ok", 8'(hi_len >= 21 && hi_len <= 30), 8'd1);
    check("pulse_done_cnt", 8'(pd_cnt), 8'd1);
    check("pulse_inactive", {7'b0, act4[1]}, 8'd0);

    // 4. Degenerate blinks.
    cycle(1, 2, 2, 0, 5);
    cycle(1, 3, 2, 4, 0);
    idle(35);
    check("dark_blink", {6'b0, led4[2], act4[2]}, 8'b01);
    check("lit_blink",  {6'b0, led4[3], act4[3]}, 8'b11);
    cycle(1, 1, 2, 0, 0);
    idle(25);

    // 5. ch3 blinks 3/2 while ch2 (blink 1/3) is rewritten SOLID on a tick edge
    //    during its off phase.
    cycle(1, 3, 2, 3, 2);
    cycle(1, 2, 2, 1, 3);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (((m_k + 1) % DIV == 0) && m_n[2] > 0 &&
          !model_lit(m_mode[2], m_on[2], m_off[2], m_n[2])) found = 1'b1;
      else cycle(0, 0, 0, 0, 0);
    end
    check("wait_tick_off", 8'(found), 8'd1);
    cycle(1, 2, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    check("solid_next", {7'b0, led4[2]}, 8'd1);
    idle(60);

    // 6. Write to ch3 on the CH=3 build is dropped (ch0..2 made static first).
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    idle(3);
    snap = {led3, act3, pd3};
    cycle(1, 3, 1, 0, 0);
    idle(3);
    check("drop_ch3", {5'b0, led3, act3, pd3} >> 0, {5'b0, snap[8:6], snap[5:3], snap[2:0]});

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) async_reset();
      if ($urandom_range(19) == 0)
        cycle(1, int'($urandom_range(3)), int'($urandom_range(3)),
              int'($urandom_range(5)), int'($urandom_range(5)));
      else
        cycle(0, 0, 0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
